mem_access_stage: RTL

Pipeline MEM-stage controller between the EX/MEM and MEM/WB pipeline registers. It turns an EX/MEM load or store into a valid/ready transaction on a variable-latency data-memory port, aligns store data and byte strobes, and sign- or zero-extends load data. While a transaction is outstanding it holds `stall` high, freezing every pipeline register. It releases `stall` for exactly one cycle so that the result is captured and the access retires.

---
 rtl/mem_access_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store controller. It issues EX/MEM accesses
// on a valid/ready data port, formats store lanes and extends load data.
// Optional macro MEM_ACCESS_SUBWORD_EN enables byte/half accesses.
// Ports: clk, rstn (sync, active-low); r_valid/w_valid/addr/wdata/funct3 from EX/MEM;
// mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb request, mem_ready/mem_resp/mem_rdata reply;
// stall freezes the pipeline; mdr is the load result and err flags misalign/timeout.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        r_valid,
  input  logic        w_valid,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] mdr,
  output logic        err
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          acc, mis, tmo;
  logic [3:0]    wstrb_n;
  logic [31:0]   wdata_n, ext;

  assign acc = r_valid | w_valid;
  // The counter starts at 0 in the first RESP cycle, so the last
  // permitted wait cycle is the one where it reads TIMEOUT-1.
  assign tmo = cnt == CMAX;

`ifdef MEM_ACCESS_SUBWORD_EN
  size_t      sz, sz_q;
  logic       uns_q;
  logic [1:0] off_q;
  logic [7:0] rb;
  logic [15:0] rh;

  // Stores decode the full funct3; loads use bit 2 only as the
  // unsigned flag, so LBU/LHU share the size of LB/LH.
  always_comb begin
    sz = SZ_W;
    unique case (1'b1)
      w_valid && funct3 == 3'b000:       sz = SZ_B;
      w_valid && funct3 == 3'b001:       sz = SZ_H;
      !w_valid && funct3[1:0] == 2'b00: sz = SZ_B;
      !w_valid && funct3[1:0] == 2'b01: sz = SZ_H;
      default:                           sz = SZ_W;
    endcase
  end

  assign mis = (sz == SZ_H && addr[0]) ||
               (sz == SZ_W && addr[1:0] != 2'b00);

  always_comb begin
    wstrb_n = '0;
    wdata_n = '0;
    if (w_valid) begin
      unique case (sz)
        SZ_B: begin
          wstrb_n = 4'b0001 << addr[1:0];
          wdata_n = {4{wdata[7:0]}};
        end
        SZ_H: begin
          wstrb_n = 4'b0011 << {addr[1], 1'b0};
          wdata_n = {2{wdata[15:0]}};
        end
        default: begin
          wstrb_n = 4'b1111;
          wdata_n = wdata;
        end
      endcase
    end
  end

  assign rb = 8'(mem_rdata >> {off_q, 3'b000});
  assign rh = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    unique case (sz_q)
      SZ_B:    ext = {{24{rb[7] & ~uns_q}}, rb};
      SZ_H:    ext = {{16{rh[15] & ~uns_q}}, rh};
      default: ext = mem_rdata;
    endcase
  end

  // Load shape is latched with the request so extraction does not
  // depend on EX/MEM staying frozen.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sz_q  <= SZ_W;
      uns_q <= 1'b0;
      off_q <= 2'b00;
    end else if (state == IDLE && acc && !mis) begin
      sz_q  <= sz;
      uns_q <= funct3[2];
      off_q <= addr[1:0];
    end
  end
`else
  logic unused_f3;
  assign unused_f3 = ^funct3;
  assign mis       = addr[1:0] != 2'b00;
  assign wstrb_n   = w_valid ? 4'b1111 : 4'b0000;
  assign wdata_n   = w_valid ? wdata : '0;
  assign ext       = mem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        stall = acc;
        if (acc) state_n = mis ? DONE : REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) state_n = RESP;
      end
      RESP: begin
        stall = 1'b1;
        if (mem_resp || tmo) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cnt       <= '0;
      mdr       <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc && mis) begin
            err <= 1'b1;
            mdr <= '0;
          end else if (acc) begin
            mem_we    <= w_valid;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata_n;
            mem_wstrb <= wstrb_n;
          end
        end
        REQ: begin
          if (mem_ready) cnt <= '0;
        end
        RESP: begin
          if (mem_resp) begin
            mdr <= mem_we ? '0 : ext;
          end else if (tmo) begin
            err <= 1'b1;
            mdr <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
